// File: rtl/fp_cl_encode_pkg.sv
// Shared types and RV32F encoding constants for the FP instruction encoder.
package fp_cl_encode_pkg;

    typedef enum logic [4:0] {
        e_fadd, e_fsub, e_fmul, e_fmin, e_fmax, e_fsgnj, e_fsgnjn, e_fsgnjx,
        e_fmadd, e_fmsub, e_fnmsub, e_fnmadd, e_fcvt_s_w, e_fcvt_s_wu, e_fmv_w_x
    } fpu_float_op_e;

    typedef enum logic [2:0] {
        e_feq, e_fle, e_flt, e_fcvt_w_s, e_fcvt_wu_s, e_fclass, e_fmv_x_w
    } fpu_int_op_e;

    typedef struct packed {
        logic          is_fpu_float_op;
        logic          is_fpu_int_op;
        logic          is_fdiv_op;
        logic          is_fsqrt_op;
        fpu_float_op_e fpu_float_op;
        fpu_int_op_e   fpu_int_op;
    } fp_decode_s;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] op;
    } instruction_s;

    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;

    localparam logic [6:0] F7_FADD    = 7'b0000000;
    localparam logic [6:0] F7_FSUB    = 7'b0000100;
    localparam logic [6:0] F7_FMUL    = 7'b0001000;
    localparam logic [6:0] F7_FDIV    = 7'b0001100;
    localparam logic [6:0] F7_FSQRT   = 7'b0101100;
    localparam logic [6:0] F7_FSGNJ   = 7'b0010000;
    localparam logic [6:0] F7_FMINMAX = 7'b0010100;
    localparam logic [6:0] F7_FCVT_WS = 7'b1100000;
    localparam logic [6:0] F7_FCVT_SW = 7'b1101000;
    localparam logic [6:0] F7_FCMP    = 7'b1010000;
    localparam logic [6:0] F7_FCLASS  = 7'b1110000;
    localparam logic [6:0] F7_FMV_W_X = 7'b1111000;

    // Exactly one op class selected, and the op enum valid within that class.
    function automatic logic fp_decode_legal(fp_decode_s d);
        logic ok;
        ok = {d.is_fpu_float_op, d.is_fpu_int_op, d.is_fdiv_op, d.is_fsqrt_op}
             inside {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        if (d.is_fpu_float_op && (d.fpu_float_op > e_fmv_w_x)) ok = 1'b0;
        if (d.is_fpu_int_op && (d.fpu_int_op > e_fmv_x_w)) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/fp_cl_encode_fifo.sv
// Output buffer for the FP encoder: circular FIFO with wrap-extended pointers.
// els_p must be a power of two, at least 2.
module fp_cl_encode_fifo #(
    parameter int els_p   = 2,
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PtrW = $clog2(els_p);
    localparam logic [PtrW:0] PtrOne = 1;

    logic [PtrW:0]      wptr, rptr;
    logic [width_p-1:0] mem [els_p];

    // Same slot, opposite lap: full. Identical pointers: empty.
    assign full_o  = (wptr[PtrW] != rptr[PtrW]) && (wptr[PtrW-1:0] == rptr[PtrW-1:0]);
    assign empty_o = (wptr == rptr);
    assign data_o  = mem[rptr[PtrW-1:0]];

    // Pointer advance; reset empties the buffer immediately.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_i) wptr <= wptr + PtrOne;
            if (pop_i)  rptr <= rptr + PtrOne;
        end
    end

    // Storage; push while full is only issued alongside a pop of the same slot.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wptr[PtrW-1:0]] <= data_i;
    end

`ifndef SYNTHESIS
    // Consumer must never take from an empty buffer.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && pop_i) assert (!empty_o) else $error("pop from empty buffer");
    end
`endif

endmodule

// File: rtl/fp_cl_encode.sv
// Streaming RV32F encoder: descriptor -> encode register -> 2-entry buffer -> 32-bit word.
// Optional FP_CL_ENCODE_PERF_EN adds saturating issued/error counters.
module fp_cl_encode
    import fp_cl_encode_pkg::*;
#(
    parameter int els_p = 2
`ifdef FP_CL_ENCODE_PERF_EN
    , parameter int count_width_p = 32
`endif
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [$bits(fp_decode_s)-1:0]  fp_decode_i,
    input  logic [4:0]                     rd_i,
    input  logic [4:0]                     rs1_i,
    input  logic [4:0]                     rs2_i,
    input  logic [4:0]                     rs3_i,
    input  logic [2:0]                     rm_i,
    output logic                           v_o,
    input  logic                           yumi_i,
    output logic [31:0]                    instr_o,
    output logic                           err_o,
    input  logic                           err_clear_i
`ifdef FP_CL_ENCODE_PERF_EN
    ,
    output logic [count_width_p-1:0]       issued_count_o,
    output logic [count_width_p-1:0]       err_count_o
`endif
);

    fp_decode_s   desc_in, stage_desc;
    logic         out_of_reset, stage_valid, err_flag;
    logic [4:0]   stage_rd, stage_rs1, stage_rs2, stage_rs3;
    logic [2:0]   stage_rm;
    logic         fifo_full, fifo_empty, push, accept, err_set;
    logic [31:0]  fifo_data;
    instruction_s enc;

    assign desc_in = fp_decode_s'(fp_decode_i);
    // Stage drains when the buffer has room or is making room this cycle.
    assign push    = stage_valid & (~fifo_full | yumi_i);
    assign ready_o = out_of_reset & (~stage_valid | ~fifo_full | yumi_i);
    assign accept  = v_i & ready_o;
    assign err_set = accept & ~fp_decode_legal(desc_in);
    assign v_o     = ~fifo_empty;
    assign instr_o = fifo_empty ? 32'h0 : fifo_data;
    assign err_o   = err_flag;

    // Holds ready low for the first cycle after reset release.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) out_of_reset <= 1'b0;
        else            out_of_reset <= 1'b1;
    end

    // Encode register: capture on accept, empty once pushed into the buffer.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            stage_valid <= 1'b0;
            stage_desc  <= '0;
            stage_rd    <= '0;
            stage_rs1   <= '0;
            stage_rs2   <= '0;
            stage_rs3   <= '0;
            stage_rm    <= '0;
        end else if (accept) begin
            stage_valid <= 1'b1;
            stage_desc  <= desc_in;
            stage_rd    <= rd_i;
            stage_rs1   <= rs1_i;
            stage_rs2   <= rs2_i;
            stage_rs3   <= rs3_i;
            stage_rm    <= rm_i;
        end else if (push) begin
            stage_valid <= 1'b0;
        end
    end

    // Sticky error: a new illegal accept beats a simultaneous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) err_flag <= 1'b0;
        else            err_flag <= err_set | (err_flag & ~err_clear_i);
    end

    // Build the instruction word from the registered descriptor; illegal -> all zeros.
    always_comb begin
        enc = '0;
        if (fp_decode_legal(stage_desc)) begin
            enc.op     = OPC_OP_FP;
            enc.rd     = stage_rd;
            enc.rs1    = stage_rs1;
            enc.rs2    = stage_rs2;
            enc.funct3 = stage_rm;
            enc.funct7 = F7_FADD;
            if (stage_desc.is_fdiv_op) begin
                enc.funct7 = F7_FDIV;
            end else if (stage_desc.is_fsqrt_op) begin
                enc.funct7 = F7_FSQRT;
                enc.rs2    = 5'd0;
            end else if (stage_desc.is_fpu_float_op) begin
                case (stage_desc.fpu_float_op)
                    e_fadd:      enc.funct7 = F7_FADD;
                    e_fsub:      enc.funct7 = F7_FSUB;
                    e_fmul:      enc.funct7 = F7_FMUL;
                    e_fmin:      begin enc.funct7 = F7_FMINMAX; enc.funct3 = 3'b000; end
                    e_fmax:      begin enc.funct7 = F7_FMINMAX; enc.funct3 = 3'b001; end
                    e_fsgnj:     begin enc.funct7 = F7_FSGNJ;   enc.funct3 = 3'b000; end
                    e_fsgnjn:    begin enc.funct7 = F7_FSGNJ;   enc.funct3 = 3'b001; end
                    e_fsgnjx:    begin enc.funct7 = F7_FSGNJ;   enc.funct3 = 3'b010; end
                    // R4 format: rs3 and fmt=00 occupy the funct7 slot.
                    e_fmadd:     begin enc.op = OPC_FMADD;  enc.funct7 = {stage_rs3, 2'b00}; end
                    e_fmsub:     begin enc.op = OPC_FMSUB;  enc.funct7 = {stage_rs3, 2'b00}; end
                    e_fnmsub:    begin enc.op = OPC_FNMSUB; enc.funct7 = {stage_rs3, 2'b00}; end
                    e_fnmadd:    begin enc.op = OPC_FNMADD; enc.funct7 = {stage_rs3, 2'b00}; end
                    e_fcvt_s_w:  begin enc.funct7 = F7_FCVT_SW; enc.rs2 = 5'd0; end
                    e_fcvt_s_wu: begin enc.funct7 = F7_FCVT_SW; enc.rs2 = 5'd1; end
                    e_fmv_w_x:   begin
                        enc.funct7 = F7_FMV_W_X; enc.funct3 = 3'b000; enc.rs2 = 5'd0;
                    end
                    default:     enc = '0;
                endcase
            end else begin
                case (stage_desc.fpu_int_op)
                    e_feq:       begin enc.funct7 = F7_FCMP; enc.funct3 = 3'b010; end
                    e_flt:       begin enc.funct7 = F7_FCMP; enc.funct3 = 3'b001; end
                    e_fle:       begin enc.funct7 = F7_FCMP; enc.funct3 = 3'b000; end
                    e_fcvt_w_s:  begin enc.funct7 = F7_FCVT_WS; enc.rs2 = 5'd0; end
                    e_fcvt_wu_s: begin enc.funct7 = F7_FCVT_WS; enc.rs2 = 5'd1; end
                    e_fclass:    begin
                        enc.funct7 = F7_FCLASS; enc.funct3 = 3'b001; enc.rs2 = 5'd0;
                    end
                    e_fmv_x_w:   begin
                        enc.funct7 = F7_FCLASS; enc.funct3 = 3'b000; enc.rs2 = 5'd0;
                    end
                    default:     enc = '0;
                endcase
            end
        end
    end

    fp_cl_encode_fifo #(
        .els_p   (els_p),
        .width_p (32)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (push),
        .data_i    (enc),
        .pop_i     (yumi_i),
        .data_o    (fifo_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

`ifdef FP_CL_ENCODE_PERF_EN
    localparam logic [count_width_p-1:0] CntOne = 1;
    logic [count_width_p-1:0] issued_count, err_count;

    // Saturating event counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            issued_count <= '0;
            err_count    <= '0;
        end else begin
            if (v_o && yumi_i && (issued_count != '1)) issued_count <= issued_count + CntOne;
            if (err_set && (err_count != '1))          err_count    <= err_count + CntOne;
        end
    end

    assign issued_count_o = issued_count;
    assign err_count_o    = err_count;
`endif

endmodule

// File: doc/fp_cl_encode.md
Name: fp_cl_encode

Overview:
- Streaming RV32F instruction encoder: accepts an fp_decode_s descriptor plus register/rounding fields over valid/ready and emits the 32-bit instruction_s word.
- Inverse of the FP decode path. Used by the FP test stimulus generator and by the trace-replay front end to synthesize FP instruction streams into the vanilla core's icache fill path.
- One-cycle encode register followed by a 2-entry output buffer, so both sides tolerate back-pressure without combinational ready paths.

Parameters:
- els_p, 2, output buffer depth; must be 2 (power of two, ≥2).
- count_width_p, 32, width of issued/error counters.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- v_i  in  1  descriptor valid
- ready_o  out  1  encoder can accept this cycle
- fp_decode_i  in  $bits(fp_decode_s)  op selection (is_fpu_float_op / is_fpu_int_op / is_fdiv_op / is_fsqrt_op, fpu_float_op, fpu_int_op)
- rd_i, rs1_i, rs2_i, rs3_i  in  5 each  register fields
- rm_i  in  3  rounding mode for arithmetic/FMA/div/sqrt/cvt ops
- v_o  out  1  encoded instruction valid
- yumi_i  in  1  consumer takes instruction (only when v_o)
- instr_o  out  32 (instruction_s)  encoded word
- err_o  out  1  sticky illegal-descriptor flag
- err_clear_i  in  1  clears err_o

Behaviour:
- Reset (async assert, sync deassert at the flop): v_o=0, ready_o=0 in the reset cycle, then 1; instr_o=0; err_o=0; buffer empty; counters 0.
- Encode stage:
  - Handshake v_i&ready_o registers the descriptor; the word is formed combinationally from the registered descriptor.
  - Pushed into the buffer next cycle. Latency from accept to v_o = 2 cycles when the buffer is empty.
  - Throughput 1/cycle when yumi_i is held high.
- ready_o = encode stage empty OR encode stage will drain this cycle (buffer not full, or full and yumi_i). Registered-style: derived from buffer count and yumi_i only, never from v_i.
- Buffer: 2-entry circular FIFO, 1-bit wrap-extended read/write pointers. Full when pointers differ only in the wrap bit. Push and pop in the same cycle while full is legal and keeps it full. Pop when empty is illegal (assert).
- Encoding:
  - fmt[26:25]=00 always.
  - OP-FP opcode 1010011, funct7 per op: FADD 0000000, FSUB 0000100, FMUL 0001000, FDIV 0001100, FSQRT 0101100 (rs2=0), FSGNJ/N/X 0010000 (funct3 000/001/010), FMIN/FMAX 0010100 (000/001), FCVT.W.S/WU.S 1100000 (rs2=0/1), FCVT.S.W/WU 1101000 (rs2=0/1), FEQ/FLT/FLE 1010000 (funct3 010/001/000), FCLASS 1110000 (funct3 001, rs2=0), FMV.X.W 1110000 (funct3 000, rs2=0), FMV.W.X 1111000 (funct3 000, rs2=0).
  - FMA opcodes: FMADD 1000011, FMSUB 1000111, FNMSUB 1001011, FNMADD 1001111; rs3 in [31:27].
  - funct3 = rm_i for FADD/FSUB/FMUL/FDIV/FSQRT/FCVT/FMA.
  - Unused register fields are forced to 0 regardless of input.
- Illegal descriptor = not exactly one of the four is_* bits set, or an enum value outside its op class.
  - The descriptor is still accepted and emitted as 32'h0000_0000.
  - err_o sets on the cycle after acceptance.
  - err_clear_i and a new error in the same cycle: set wins.
- Reset mid-stream discards the encode stage and buffer contents immediately.

Optional Feature:
- FP_CL_ENCODE_PERF_EN:
  - Defined: adds outputs issued_count_o and err_count_o (count_width_p each). Issued increments on each v_o&yumi_i; err increments on each illegal acceptance. Both saturate at all-ones.
  - Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- bsg_vanilla_pkg: fp_decode_s, fpu_float_op_e, fpu_int_op_e, instruction_s already exist there. Add constants for RV32 opcodes OP_FP/FMADD/FMSUB/FNMSUB/FNMADD and the funct7 values listed above as localparams in the package.
- One sub-module: fp_cl_encode_fifo (2-entry buffer with wrap-bit pointers).

Test Plan:
- FADD, rd=3 rs1=1 rs2=2 rm=000, yumi_i=1 → instr_o=32'h002081D3 two cycles after accept; err_o=0.
- FMADD rd=5 rs1=6 rs2=7 rs3=8 rm=111 → instr_o=32'h40737 2C3 (0x407372C3); FSQRT rs2_i=9 → rs2 field 0.
- Back-pressure: 4 back-to-back descriptors, yumi_i=0 → ready_o drops after 3 accepts (stage+2 entries). yumi_i=1 → words emerge in order with no loss or duplication.
- Full buffer with push+pop in the same cycle → count stays 2, order preserved.
- Descriptor with is_fpu_float_op=1 and is_fdiv_op=1 → instr_o=0, err_o=1 next cycle. err_clear_i clears it; set beats clear when simultaneous.
- Assert reset_n_i=0 with 2 buffered words → v_o=0 asynchronously; after release ready_o=1 and buffer empty.
